// File: rtl/seq_pkg.sv
// seq_pkg: shared defaults, state type and index-width helper for the step sequencer voices.
package seq_pkg;
  localparam int STEPS_DEFAULT = 32;
  localparam int CNT_W_DEFAULT = 24;
  localparam int TRIG_LEN_DEFAULT = 16;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/seq_pulse_gen.sv
// seq_pulse_gen: retriggerable one-shot, trig high TRIG_LEN cycles after the last fire; clear truncates.
module seq_pulse_gen #(
  parameter int TRIG_LEN = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic fire,
  input  logic clear,
  output logic trig
);
  localparam int PW = TRIG_LEN > 1 ? $clog2(TRIG_LEN) : 1;
  logic [PW-1:0] pcnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trig <= 1'b0;
      pcnt <= '0;
    end else if (clear) begin
      trig <= 1'b0;
      pcnt <= '0;
    end else if (fire) begin
      trig <= 1'b1;
      pcnt <= PW'(TRIG_LEN - 1);
    end else if (pcnt != '0) begin
      pcnt <= pcnt - PW'(1);
    end else begin
      trig <= 1'b0;
    end
  end
endmodule

// File: rtl/seq_clap_step_trigger.sv
// seq_clap_step_trigger: steps the clap pattern at a programmable tempo and fires the clap voice.
// Define SEQ_CLAP_SWING_EN to add the swing input (alternating long/short step intervals).
module seq_clap_step_trigger
  import seq_pkg::*;
#(
  parameter int STEPS    = STEPS_DEFAULT,
  parameter int CNT_W    = CNT_W_DEFAULT,
  parameter int TRIG_LEN = TRIG_LEN_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [STEPS-1:0]          pattern,
  input  logic                      run,
  input  logic                      sync_restart,
  input  logic [CNT_W-1:0]          step_period,
  input  logic [idx_w(STEPS):0]     num_steps,
`ifdef SEQ_CLAP_SWING_EN
  input  logic [CNT_W-2:0]          swing,
`endif
  output logic                      trig,
  output logic                      step_strobe,
  output logic [idx_w(STEPS)-1:0]   step_idx
);
  localparam int IW = idx_w(STEPS);
  state_t           state;
  logic [CNT_W:0]   cnt, load;
  logic [STEPS-1:0] shadow, shadow_n;
  logic [CNT_W-1:0] eff_period;
  logic [IW:0]      eff_steps;
  logic [IW-1:0]    nxt_idx;
  logic             restart, start, fire, clear;
`ifdef SEQ_CLAP_SWING_EN
  logic [CNT_W-1:0] half_m1, s;
`endif
  always_comb begin
    eff_period = step_period < CNT_W'(2) ? CNT_W'(2) : step_period;
    eff_steps = (num_steps == '0 || num_steps > (IW+1)'(STEPS)) ? (IW+1)'(STEPS) : num_steps;
    restart = state == IDLE || sync_restart;
    start = run && (restart || cnt == '0);
    nxt_idx = (restart || {1'b0, step_idx} + (IW+1)'(1) >= eff_steps) ? '0 : step_idx + IW'(1);
    shadow_n = start ? pattern : shadow;
    fire = start && shadow_n[nxt_idx];
    clear = state == RUN && !run;
`ifdef SEQ_CLAP_SWING_EN
    // clamp keeps the short (odd) step at least eff_period/2+1 cycles
    half_m1 = eff_period / CNT_W'(2) - CNT_W'(1);
    s = CNT_W'(swing) > half_m1 ? half_m1 : CNT_W'(swing);
    load = nxt_idx[0] ? {1'b0, eff_period} - {1'b0, s} - (CNT_W+1)'(1)
                      : {1'b0, eff_period} + {1'b0, s} - (CNT_W+1)'(1);
`else
    load = {1'b0, eff_period} - (CNT_W+1)'(1);
`endif
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      step_strobe <= 1'b0;
      step_idx <= '0;
      cnt <= '0;
      shadow <= '0;
    end else begin
      state <= run ? RUN : IDLE;
      step_strobe <= start;
      shadow <= shadow_n;
      if (start) begin
        step_idx <= nxt_idx;
        cnt <= load;
      end else if (!run) begin
        step_idx <= '0;
        cnt <= '0;
      end else if (cnt != '0) begin
        cnt <= cnt - (CNT_W+1)'(1);
      end
    end
  end
  seq_pulse_gen #(.TRIG_LEN(TRIG_LEN)) u_pulse (
    .clk(clk), .reset_n(reset_n), .fire(fire), .clear(clear), .trig(trig)
  );
endmodule

// File: tb/tb_seq_clap_step_trigger.sv
// tb_seq_clap_step_trigger: event-time reference model plus directed literal checks.
// Define SEQ_CLAP_SWING_EN to also exercise the swing input.
module tb_seq_clap_step_trigger;
  localparam int TRIG_LEN = 16;
  logic clk = 1'b0, reset_n = 1'b0, run = 1'b0, sync_restart = 1'b0;
  logic [31:0] pattern = '0;
  logic [23:0] step_period = 24'd4;
  logic [5:0]  num_steps = '0;
`ifdef SEQ_CLAP_SWING_EN
  logic [22:0] swing = '0;
`endif
  logic trig, step_strobe;
  logic [4:0] step_idx;
  int checks = 0, errors = 0;

  seq_clap_step_trigger dut (
    .clk(clk), .reset_n(reset_n), .pattern(pattern), .run(run), .sync_restart(sync_restart),
    .step_period(step_period), .num_steps(num_steps),
`ifdef SEQ_CLAP_SWING_EN
    .swing(swing),
`endif
    .trig(trig), .step_strobe(step_strobe), .step_idx(step_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: absolute edge times for the next step start and the end of the trigger pulse.
  bit m_run = 0, m_strobe = 0;
  int cyc = 0, next_start = 0, trig_until = -1, m_idx = 0;

  function automatic int effp();
    return step_period < 2 ? 2 : int'(step_period);
  endfunction
  function automatic int effs();
    return (num_steps == 0 || num_steps > 32) ? 32 : int'(num_steps);
  endfunction
  function automatic int interval(input int i);
`ifdef SEQ_CLAP_SWING_EN
    int e, s;
    e = effp();
    s = int'(swing) < e / 2 - 1 ? int'(swing) : e / 2 - 1;
    return i % 2 ? e - s : e + s;
`else
    return effp();
`endif
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_run = 0; m_strobe = 0; m_idx = 0; trig_until = -1;
    end else begin
      cyc++;
      if (!run) begin
        m_run = 0; m_strobe = 0; m_idx = 0; trig_until = -1;
      end else begin
        if (!m_run || sync_restart || cyc == next_start) begin
          m_idx = (!m_run || sync_restart || m_idx + 1 >= effs()) ? 0 : m_idx + 1;
          next_start = cyc + interval(m_idx);
          if (pattern[m_idx]) trig_until = cyc + TRIG_LEN - 1;
          m_strobe = 1;
        end else m_strobe = 0;
        m_run = 1;
      end
    end
    #1;
    chk("model_strobe", step_strobe, m_strobe);
    chk("model_idx", step_idx, m_idx);
    chk("model_trig", trig, (reset_n && cyc <= trig_until) ? 1 : 0);
  end

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idx(input int v, input int budget);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (step_strobe && step_idx == 5'(v)) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_idx: step_idx %0d not reached within %0d cycles (last %0d)", v, budget, step_idx);
    end
  endtask

  initial begin
    ticks(3);
    chk("reset_trig", trig, 0);
    chk("reset_strobe", step_strobe, 0);
    chk("reset_idx", step_idx, 0);
    reset_n = 1'b1;
    ticks(2);
    // basic stepping: period 4, 4 steps
    pattern = 32'h5; step_period = 4; num_steps = 4; run = 1;
    ticks(1);
    chk("t1_strobe0", step_strobe, 1); chk("t1_idx0", step_idx, 0); chk("t1_trig0", trig, 1);
    ticks(4);
    chk("t1_strobe1", step_strobe, 1); chk("t1_idx1", step_idx, 1);
    ticks(1);
    chk("t1_strobe_gap", step_strobe, 0);
    ticks(3);
    chk("t1_idx2", step_idx, 2);
    ticks(8);
    chk("t1_wrap", step_idx, 0); chk("t1_wrap_strobe", step_strobe, 1);
    run = 0;
    ticks(1);
    chk("t1_stop_trig", trig, 0); chk("t1_stop_idx", step_idx, 0);
    ticks(2);
    // retrigger keeps trig high 26 cycles
    pattern = 32'h3; step_period = 10; num_steps = 0; run = 1;
    ticks(26);
    chk("t2_trig_hi", trig, 1);
    ticks(1);
    chk("t2_trig_lo", trig, 0);
    run = 0;
    ticks(2);
    // pattern change mid step 0
    pattern = 32'h1; step_period = 20; num_steps = 4; run = 1;
    ticks(1);
    chk("t3_trig0", trig, 1);
    ticks(2);
    pattern = 32'h2;
    ticks(14);
    chk("t3_trig_end", trig, 0);
    ticks(4);
    chk("t3_trig1", trig, 1); chk("t3_idx1", step_idx, 1);
    run = 0;
    ticks(2);
    // sync_restart at step 5
    pattern = 32'hA5; step_period = 3; num_steps = 8; run = 1;
    wait_idx(5, 60);
    sync_restart = 1;
    ticks(1);
    sync_restart = 0;
    chk("t4_restart_strobe", step_strobe, 1); chk("t4_restart_idx", step_idx, 0);
    ticks(2);
    chk("t4_gap", step_strobe, 0);
    ticks(1);
    chk("t4_next_strobe", step_strobe, 1); chk("t4_next_idx", step_idx, 1);
    // shrink sequence below current index
    wait_idx(6, 60);
    num_steps = 4;
    ticks(3);
    chk("t6_shrink_idx", step_idx, 0); chk("t6_shrink_strobe", step_strobe, 1);
    ticks(5);
    // run=0 wins over sync_restart
    run = 0; sync_restart = 1;
    ticks(1);
    sync_restart = 0;
    chk("t7_strobe", step_strobe, 0); chk("t7_idx", step_idx, 0); chk("t7_trig", trig, 0);
    ticks(3);
    chk("t7_idle", step_strobe, 0);
    // minimum period, full 32 steps
    pattern = 32'h8000_0001; step_period = 0; num_steps = 0; run = 1;
    ticks(63);
    chk("t5_idx31", step_idx, 31); chk("t5_strobe31", step_strobe, 1);
    ticks(2);
    chk("t5_wrap", step_idx, 0); chk("t5_wrap_strobe", step_strobe, 1);
    ticks(10);
    run = 0;
    ticks(2);
    // asynchronous reset mid pulse
    pattern = 32'h1; step_period = 5; num_steps = 0; run = 1;
    ticks(3);
    #2 reset_n = 0;
    #1 chk("t8_async_trig", trig, 0);
    ticks(1);
    reset_n = 1;
    ticks(1);
    chk("t8_restart_strobe", step_strobe, 1); chk("t8_restart_idx", step_idx, 0);
    ticks(4);
    run = 0;
    ticks(2);
`ifdef SEQ_CLAP_SWING_EN
    pattern = 32'h0; step_period = 8; swing = 10; num_steps = 0; run = 1;
    ticks(12);
    chk("sw_strobe1", step_strobe, 1); chk("sw_idx1", step_idx, 1);
    ticks(5);
    chk("sw_strobe2", step_strobe, 1); chk("sw_idx2", step_idx, 2);
    ticks(20);
    run = 0;
    ticks(2);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
